// File: rtl/ppm_encoder_pkg.sv
// Shared PPM framing definitions: FSM state encoding and symbol-geometry helpers
// used by both the encoder and the matching decoder.
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        SYMBOLS  = 2'd2,
        GAP      = 2'd3
    } ppm_state_t;

    function automatic int slots(input int n_mod);
        return 1 << n_mod;
    endfunction

    function automatic int nsym(input int n_pkt, input int n_mod);
        return n_pkt / n_mod;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ppm_encoder_if.sv
// Upstream word handshake (data/avail/read) plus the encoder's line and status outputs.
interface ppm_encoder_if #(
    parameter int N_PKT = 8
);
    logic [N_PKT-1:0] data;
    logic             avail;
    logic             read;
    logic             pulse;
    logic             busy;

    modport master (output data, avail, input read, pulse, busy);
    modport slave  (input data, avail, output read, pulse, busy);
endinterface

// File: rtl/ppm_encoder_slot_timer.sv
// Position counter within one slot; o_pulse_on looks one cycle ahead so the
// encoder can register its pulse output without adding latency.
module ppm_encoder_slot_timer #(
    parameter int L        = 10000,
    parameter int PULSE_CT = 7500
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_slot_end,
    output logic o_pulse_on
);
    localparam int CNT_W = $clog2(L);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign o_slot_end = i_en && (r_cnt == CNT_W'(L - 1));

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear)
            w_cnt_next = '0;
        else if (i_en)
            w_cnt_next = o_slot_end ? '0 : r_cnt + CNT_W'(1);
    end

    // High when the count in the coming cycle lies inside the pulse window.
    assign o_pulse_on = (w_cnt_next < CNT_W'(PULSE_CT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_next;
    end

endmodule

// File: rtl/ppm_encoder.sv
// PPM transmit framer: accepts a word, sends PRE_CT preamble pulses, then the
// payload as MSB-first PPM symbols, then holds off for a guard gap.
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int PULSE_CT = 7500,
    parameter int N_MOD    = 2,
    parameter int L        = 10000,
    parameter int N_PKT    = 8,
    parameter int PRE_CT   = 4,
    parameter int GAP_CT   = 20000
) (
    input logic         clk,
    input logic         rst,
    ppm_encoder_if.slave bus
);
    localparam int NS     = nsym(N_PKT, N_MOD);
    localparam int SL     = slots(N_MOD);
    localparam int SLOT_W = $clog2(max2(PRE_CT, SL));
    localparam int SYM_W  = $clog2(NS) + 1;
    localparam int GAP_W  = max2(1, $clog2(GAP_CT + 1));

    if (PULSE_CT >= L || PULSE_CT <= 0 || (N_PKT % N_MOD) != 0 || PRE_CT < 1) begin : g_bad_params
        $fatal(1, "ppm_encoder: illegal parameter combination");
    end

    ppm_state_t        r_state, w_state_next;
    logic [SLOT_W-1:0] r_slot, w_slot_next, w_sym_val;
    logic [SYM_W-1:0]  r_sym, w_sym_next;
    logic [N_PKT-1:0]  r_shift, w_shift_next;
    logic [GAP_W-1:0]  r_gap, w_gap_next;
    logic              r_read, w_read_next;
    logic              r_pulse, r_busy;
    logic              w_clear, w_en, w_slot_end, w_pulse_on, w_hit_next;

    assign w_en    = (r_state == PREAMBLE) || (r_state == SYMBOLS);
    assign w_clear = (r_state == IDLE) && bus.avail;

    ppm_encoder_slot_timer #(
        .L        (L),
        .PULSE_CT (PULSE_CT)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_en       (w_en),
        .o_slot_end (w_slot_end),
        .o_pulse_on (w_pulse_on)
    );

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        w_sym_next   = r_sym;
        w_shift_next = r_shift;
        w_gap_next   = r_gap;
        w_read_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.avail) begin
                    w_state_next = PREAMBLE;
                    w_shift_next = bus.data;
                    w_slot_next  = '0;
                    w_sym_next   = '0;
                    w_read_next  = 1'b1;
                end
            end
            PREAMBLE: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(PRE_CT - 1)) begin
                        w_state_next = SYMBOLS;
                        w_slot_next  = '0;
                    end else begin
                        w_slot_next = r_slot + SLOT_W'(1);
                    end
                end
            end
            SYMBOLS: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(SL - 1)) begin
                        w_slot_next  = '0;
                        w_shift_next = r_shift << N_MOD;
                        if (r_sym == SYM_W'(NS - 1)) begin
                            w_state_next = (GAP_CT == 0) ? IDLE : GAP;
                            w_gap_next   = '0;
                        end else begin
                            w_sym_next = r_sym + SYM_W'(1);
                        end
                    end else begin
                        w_slot_next = r_slot + SLOT_W'(1);
                    end
                end
            end
            GAP: begin
                if (r_gap == GAP_W'(GAP_CT - 1))
                    w_state_next = IDLE;
                else
                    w_gap_next = r_gap + GAP_W'(1);
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Pulse decision is made on next-cycle state so the line itself is a flop.
    assign w_sym_val  = SLOT_W'(w_shift_next[N_PKT-1 -: N_MOD]);
    assign w_hit_next = (w_state_next == PREAMBLE) ||
                        ((w_state_next == SYMBOLS) && (w_slot_next == w_sym_val));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_sym   <= '0;
            r_shift <= '0;
            r_gap   <= '0;
            r_read  <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            r_sym   <= w_sym_next;
            r_shift <= w_shift_next;
            r_gap   <= w_gap_next;
            r_read  <= w_read_next;
            r_pulse <= w_pulse_on && w_hit_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign bus.read  = r_read;
    assign bus.pulse = r_pulse;
    assign bus.busy  = r_busy;

endmodule
